add_acc_pipe: RTL and testbench

Two-stage pipelined arithmetic unit that generalises the combinational `ui_in + uio_in` datapath. It adds parametrised operand and accumulator widths, four operation modes (add, subtract, accumulate, clear), an overflow flag, and valid/ready flow control on both sides. It sits between the pin-level input capture and output drive logic of `top`. It replaces the direct adder assignment to `uo_out`.

---
 rtl/add_acc_pkg.sv | 12 +
 rtl/add_acc_pipe_pipe_reg.sv | 36 +++
 rtl/add_acc_pipe.sv | 136 +++++++++++++
 tb/tb_add_acc_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/add_acc_pkg.sv
// Shared types for the add/accumulate pipeline: operation codes.
// Optional build macro used by the pipeline: ADD_ACC_SATURATE_EN.
package add_acc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_t;

endpackage

// File: rtl/add_acc_pipe_pipe_reg.sv
// Single-entry valid/ready register slice with a parametrised payload.
// Accepts a new beat whenever it is empty or its current beat is leaving.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign in_ready  = !rst && (!valid_r || out_ready);
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Slice occupancy and payload; payload only changes when a beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (!valid_r || out_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/add_acc_pipe.sv
// Two-stage add/sub/accumulate/clear unit with valid/ready on both sides.
// Define ADD_ACC_SATURATE_EN to clamp SUB underflow and ACC overflow instead of wrapping.
module add_acc_pipe
  import add_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

`ifdef ADD_ACC_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_payload_t;

  localparam int unsigned S1_W = $bits(s1_payload_t);

  s1_payload_t      s1_in_s;
  s1_payload_t      s1_out_s;
  logic             s1_valid_s;
  logic             s2_load_s;

  logic             out_valid_r;
  logic             ovf_r;
  logic [ACC_W-1:0] result_r;
  logic [ACC_W-1:0] acc_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [ACC_W:0]   acc_sum_s;
  logic [ACC_W-1:0] res_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             ovf_s;

  // Pack the incoming beat for the stage-1 slice.
  always_comb begin
    s1_in_s.op = op_t'(op);
    s1_in_s.a  = a;
    s1_in_s.b  = b;
  end

  pipe_reg #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_load_s),
    .out_data  (s1_out_s)
  );

  // Stage 2 takes a beat when empty or when its current beat leaves this cycle.
  assign s2_load_s = !out_valid_r || out_ready;

  // Stage-2 arithmetic; acc_nxt_s equals acc_r unless the beat is ACC or CLR.
  always_comb begin
    sum_s     = {1'b0, s1_out_s.a} + {1'b0, s1_out_s.b};
    diff_s    = {1'b0, s1_out_s.a} - {1'b0, s1_out_s.b};
    acc_sum_s = {1'b0, acc_r} + (ACC_W+1)'(s1_out_s.a);
    res_s     = {ACC_W{1'b0}};
    acc_nxt_s = acc_r;
    ovf_s     = 1'b0;
    case (s1_out_s.op)
      OP_ADD: begin
        res_s = ACC_W'(sum_s);
        ovf_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        ovf_s = diff_s[WIDTH];
        if (SATURATE && diff_s[WIDTH]) begin
          res_s = {ACC_W{1'b0}};
        end else begin
          res_s = ACC_W'(diff_s[WIDTH-1:0]);
        end
      end
      OP_ACC: begin
        ovf_s = acc_sum_s[ACC_W];
        if (SATURATE && acc_sum_s[ACC_W]) begin
          acc_nxt_s = {ACC_W{1'b1}};
        end else begin
          acc_nxt_s = acc_sum_s[ACC_W-1:0];
        end
        res_s = acc_nxt_s;
      end
      OP_CLR: begin
        acc_nxt_s = {ACC_W{1'b0}};
      end
      default: begin
        res_s     = {ACC_W{1'b0}};
        acc_nxt_s = acc_r;
        ovf_s     = 1'b0;
      end
    endcase
  end

  // Stage-2 result and accumulator; both hold while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= {ACC_W{1'b0}};
      ovf_r       <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_s;
      if (s1_valid_s) begin
        result_r <= res_s;
        ovf_r    <= ovf_s;
        acc_r    <= acc_nxt_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_add_acc_pipe.sv
// Directed plus randomized bench for add_acc_pipe against a queue-based reference model.
// Honours ADD_ACC_SATURATE_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_add_acc_pipe;

`ifdef ADD_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int AW  = 16;
  localparam int AW9 = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [1:0]  op;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic        v9_in_valid, v9_in_ready, v9_out_valid, v9_ovf;
  logic [1:0]  v9_op;
  logic [7:0]  v9_a, v9_b;
  logic [8:0]  v9_result;

  typedef struct {
    longint res;
    bit     ov;
    longint nacc;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  exp_t   q9[$];
  longint macc, macc9;
  int     cyc, n_vec, n_err;

  always #5 clk = ~clk;

  add_acc_pipe #(.WIDTH(8), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  add_acc_pipe #(.WIDTH(8), .ACC_W(AW9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(v9_in_valid), .in_ready(v9_in_ready), .op(v9_op), .a(v9_a),
    .b(v9_b), .out_valid(v9_out_valid), .out_ready(1'b1), .result(v9_result), .ovf(v9_ovf)
  );

  // Reference arithmetic straight from the operation rules, using plain integers.
  function automatic exp_t predict(int o, longint x, longint y, int accw, longint acc);
    exp_t   e;
    longint lim;
    longint t;
    lim    = longint'(1) << accw;
    e.nacc = acc;
    e.res  = 0;
    e.ov   = 1'b0;
    e.cyc  = 0;
    case (o)
      0: begin e.res = x + y; e.ov = (x + y) >= 256; end
      1: begin e.ov = x < y; e.res = (x < y) ? (SAT ? 0 : x - y + 256) : x - y; end
      2: begin
        t      = acc + x;
        e.ov   = t >= lim;
        e.nacc = !e.ov ? t : (SAT ? lim - 1 : t - lim);
        e.res  = e.nacc;
      end
      default: e.nacc = 0;
    endcase
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock cycle: check outputs before the edge, then update the model from the handshakes.
  task automatic tick();
    bit   di, dout, d9i, d9o, exp_ir, exp_ov;
    exp_t e;
    #1;
    exp_ir = !rst && (q.size() < 2 || out_ready);
    exp_ov = (q.size() > 0) && (cyc - q[0].cyc >= 1);
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (out_valid === 1'b1 && q.size() > 0) begin
      chk("result", 64'(result), 64'(q[0].res));
      chk("ovf", 64'(ovf), 64'(q[0].ov));
    end
    exp_ir = !rst;
    exp_ov = (q9.size() > 0) && (cyc - q9[0].cyc >= 1);
    chk("in_ready9", 64'(v9_in_ready), 64'(exp_ir));
    chk("out_valid9", 64'(v9_out_valid), 64'(exp_ov));
    if (v9_out_valid === 1'b1 && q9.size() > 0) begin
      chk("result9", 64'(v9_result), 64'(q9[0].res));
      chk("ovf9", 64'(v9_ovf), 64'(q9[0].ov));
    end
    di   = in_valid && in_ready;
    dout = out_valid && out_ready;
    d9i  = v9_in_valid && v9_in_ready;
    d9o  = v9_out_valid;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      q9.delete();
      macc  = 0;
      macc9 = 0;
    end else begin
      if (dout && q.size() > 0) void'(q.pop_front());
      if (d9o && q9.size() > 0) void'(q9.pop_front());
      if (di) begin
        e = predict(int'(op), longint'(a), longint'(b), AW, macc);
        macc = e.nacc; e.cyc = cyc; q.push_back(e);
      end
      if (d9i) begin
        e = predict(int'(v9_op), longint'(v9_a), longint'(v9_b), AW9, macc9);
        macc9 = e.nacc; e.cyc = cyc; q9.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic beat(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'd0; a = 8'd0; b = 8'd0; out_ready = 1'b1;
    v9_in_valid = 1'b0; v9_op = 2'd0; v9_a = 8'd0; v9_b = 8'd0;
    cyc = 0; n_vec = 0; n_err = 0; macc = 0; macc9 = 0;
    @(posedge clk); @(negedge clk);
    tick();
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    // ADD with carry
    beat(2'd0, 8'd200, 8'd100); tick(); in_valid = 1'b0; tick();
    chk("add_result", 64'(result), 64'd300);
    chk("add_ovf", 64'(ovf), 64'd1);
    tick();

    // SUB with borrow
    beat(2'd1, 8'd5, 8'd9); tick(); in_valid = 1'b0; tick();
    chk("sub_result", 64'(result), SAT ? 64'd0 : 64'd252);
    chk("sub_ovf", 64'(ovf), 64'd1);
    tick();

    // CLR then three back-to-back ACC 255
    beat(2'd3, 8'd0, 8'd0); tick();
    beat(2'd2, 8'd255, 8'd0); tick(); tick(); tick();
    in_valid = 1'b0; tick();
    chk("acc3_result", 64'(result), 64'd765);
    chk("acc3_ovf", 64'(ovf), 64'd0);
    tick();

    // Narrow accumulator overflow on the ACC_W=9 instance
    v9_in_valid = 1'b1; v9_op = 2'd3; tick();
    v9_op = 2'd2; v9_a = 8'd250; tick(); tick();
    v9_a = 8'd20; tick();
    v9_in_valid = 1'b0; tick();
    chk("acc9_result", 64'(v9_result), SAT ? 64'd511 : 64'd8);
    chk("acc9_ovf", 64'(v9_ovf), 64'd1);
    tick();

    // Backpressure: two beats fill the pipe, the third is refused
    out_ready = 1'b0;
    beat(2'd0, 8'd1, 8'd2); tick();
    beat(2'd0, 8'd3, 8'd4); tick();
    beat(2'd0, 8'd5, 8'd6);
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    chk("stall_result", 64'(result), 64'd3);
    out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    repeat (4) tick();

    // Reset with two beats in flight
    out_ready = 1'b0;
    beat(2'd2, 8'd100, 8'd0); tick();
    beat(2'd2, 8'd50, 8'd0); tick();
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    beat(2'd2, 8'd7, 8'd0); tick(); in_valid = 1'b0; tick();
    chk("acc_after_rst", 64'(result), 64'd7);
    tick();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      op          = 2'($urandom_range(0, 3));
      a           = 8'($urandom_range(0, 255));
      b           = 8'($urandom_range(0, 255));
      out_ready   = ($urandom_range(0, 9) < 7);
      v9_in_valid = ($urandom_range(0, 1) == 1);
      v9_op       = 2'($urandom_range(0, 3));
      v9_a        = 8'($urandom_range(0, 255));
      v9_b        = 8'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0; v9_in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
